frequency_lut: RTL and testbench



---
 rtl/frequency_lut.sv | 174 +++++++++++++++++
 tb/tb_frequency_lut.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/frequency_lut.sv
// Tuner pitch classifier: frequency -> nearest note/octave, deviation in pixels, sprite colour select.
// Latency 1 cycle to the result registers; no handshake, frequency is sampled every cycle.
module frequency_lut (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  oct0,
    input  logic [2:0]  oct1,
    input  logic [2:0]  oct2,
    input  logic [2:0]  oct3,
    input  logic [2:0]  oct4,
    input  logic [2:0]  oct5,
    input  logic [2:0]  oct6,
    input  logic [2:0]  oct7,
    input  logic [2:0]  oct8,
    input  logic [2:0]  C,
    input  logic [2:0]  CHDb,
    input  logic [2:0]  D,
    input  logic [2:0]  DHEb,
    input  logic [2:0]  E,
    input  logic [2:0]  F,
    input  logic [2:0]  FHGb,
    input  logic [2:0]  G,
    input  logic [2:0]  GHAb,
    input  logic [2:0]  A,
    input  logic [2:0]  AHBb,
    input  logic [2:0]  B,
    input  logic [15:0] frequency,
    output logic [2:0]  octaveColour,
    output logic [2:0]  noteColour,
    output logic [11:0] freqOffset,
    output logic        positive
);

    localparam logic [23:0] NOMINAL [0:11] = '{
        24'd4186, 24'd4435, 24'd4699, 24'd4978, 24'd5274, 24'd5588,
        24'd5920, 24'd6272, 24'd6645, 24'd7040, 24'd7459, 24'd7902
    };
    localparam logic [23:0] BOUNDARY [0:10] = '{
        24'd4310, 24'd4567, 24'd4838, 24'd5126, 24'd5431, 24'd5754,
        24'd6096, 24'd6458, 24'd6842, 24'd7249, 24'd7680
    };

    logic [3:0]  w_k;
    logic        w_found;
    logic [23:0] w_fnorm;
    logic        w_valid;
    logic [3:0]  w_index;
    logic [23:0] w_nominal;
    logic        w_positive;
    logic [23:0] w_absd;
    logic [23:0] w_prod;
    logic [23:0] w_quot;
    logic [7:0]  w_offset;

    logic        r_valid;
    logic [3:0]  r_octave;
    logic [3:0]  r_note;
    logic [7:0]  r_offset;
    logic        r_positive;

    // Descending scan so the smallest qualifying shift is the one kept.
    always_comb begin
        w_k     = 4'd0;
        w_found = 1'b0;
        for (int k = 8; k >= 0; k--) begin
            if (({8'd0, frequency} << k) >= 24'd4068) begin
                w_k     = 4'(k);
                w_found = 1'b1;
            end
        end
    end

    assign w_fnorm = {8'd0, frequency} << w_k;
    assign w_valid = w_found && (w_fnorm < 24'd8136);

    always_comb begin
        w_index = 4'd0;
        for (int i = 0; i < 11; i++) begin
            if (w_fnorm >= BOUNDARY[i]) begin
                w_index = w_index + 4'd1;
            end
        end
    end

    assign w_nominal  = NOMINAL[w_index];
    assign w_positive = (w_fnorm >= w_nominal);
    assign w_absd     = w_positive ? (w_fnorm - w_nominal) : (w_nominal - w_fnorm);
    assign w_prod     = w_absd * 24'd5354;

    // Divide by a per-note constant rather than a generic divider.
    always_comb begin
        case (w_index)
            4'd0:    w_quot = w_prod / 24'd4186;
            4'd1:    w_quot = w_prod / 24'd4435;
            4'd2:    w_quot = w_prod / 24'd4699;
            4'd3:    w_quot = w_prod / 24'd4978;
            4'd4:    w_quot = w_prod / 24'd5274;
            4'd5:    w_quot = w_prod / 24'd5588;
            4'd6:    w_quot = w_prod / 24'd5920;
            4'd7:    w_quot = w_prod / 24'd6272;
            4'd8:    w_quot = w_prod / 24'd6645;
            4'd9:    w_quot = w_prod / 24'd7040;
            4'd10:   w_quot = w_prod / 24'd7459;
            default: w_quot = w_prod / 24'd7902;
        endcase
    end

    assign w_offset = (w_quot > 24'd159) ? 8'd159 : w_quot[7:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_octave   <= 4'd0;
            r_note     <= 4'd0;
            r_offset   <= 8'd0;
            r_positive <= 1'b0;
        end else if (w_valid) begin
            r_valid    <= 1'b1;
            r_octave   <= 4'd8 - w_k;
            r_note     <= w_index;
            r_offset   <= w_offset;
            r_positive <= w_positive;
        end else begin
            r_valid    <= 1'b0;
            r_octave   <= 4'd0;
            r_note     <= 4'd0;
            r_offset   <= 8'd0;
            r_positive <= 1'b0;
        end
    end

    always_comb begin
        octaveColour = 3'b000;
        if (r_valid) begin
            case (r_octave)
                4'd0:    octaveColour = oct0;
                4'd1:    octaveColour = oct1;
                4'd2:    octaveColour = oct2;
                4'd3:    octaveColour = oct3;
                4'd4:    octaveColour = oct4;
                4'd5:    octaveColour = oct5;
                4'd6:    octaveColour = oct6;
                4'd7:    octaveColour = oct7;
                4'd8:    octaveColour = oct8;
                default: octaveColour = 3'b000;
            endcase
        end
    end

    always_comb begin
        noteColour = 3'b000;
        if (r_valid) begin
            case (r_note)
                4'd0:    noteColour = C;
                4'd1:    noteColour = CHDb;
                4'd2:    noteColour = D;
                4'd3:    noteColour = DHEb;
                4'd4:    noteColour = E;
                4'd5:    noteColour = F;
                4'd6:    noteColour = FHGb;
                4'd7:    noteColour = G;
                4'd8:    noteColour = GHAb;
                4'd9:    noteColour = A;
                4'd10:   noteColour = AHBb;
                4'd11:   noteColour = B;
                default: noteColour = 3'b000;
            endcase
        end
    end

    assign freqOffset = r_valid ? {4'd0, r_offset} : 12'd0;
    assign positive   = r_valid & r_positive;

endmodule

// File: tb/tb_frequency_lut.sv
// Directed bench for frequency_lut: hand-computed vectors, full nominal sweep, async reset.
module tb_frequency_lut;

    logic        clock;
    logic        reset;
    logic [2:0]  oct_pix  [0:8];
    logic [2:0]  note_pix [0:11];
    logic [15:0] frequency;
    logic [2:0]  octaveColour;
    logic [2:0]  noteColour;
    logic [11:0] freqOffset;
    logic        positive;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] OCT_MARK  = 3'b101;
    localparam logic [2:0] OCT_BG    = 3'b010;
    localparam logic [2:0] NOTE_MARK = 3'b110;
    localparam logic [2:0] NOTE_BG   = 3'b001;

    int nom8 [0:11] = '{4186, 4435, 4699, 4978, 5274, 5588,
                        5920, 6272, 6645, 7040, 7459, 7902};

    frequency_lut dut (
        .clock(clock), .reset(reset),
        .oct0(oct_pix[0]), .oct1(oct_pix[1]), .oct2(oct_pix[2]),
        .oct3(oct_pix[3]), .oct4(oct_pix[4]), .oct5(oct_pix[5]),
        .oct6(oct_pix[6]), .oct7(oct_pix[7]), .oct8(oct_pix[8]),
        .C(note_pix[0]), .CHDb(note_pix[1]), .D(note_pix[2]), .DHEb(note_pix[3]),
        .E(note_pix[4]), .F(note_pix[5]), .FHGb(note_pix[6]), .G(note_pix[7]),
        .GHAb(note_pix[8]), .A(note_pix[9]), .AHBb(note_pix[10]), .B(note_pix[11]),
        .frequency(frequency),
        .octaveColour(octaveColour), .noteColour(noteColour),
        .freqOffset(freqOffset), .positive(positive)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Only the expected octave/note sprite carries the marker colour.
    task automatic set_markers(input int o, input int n);
        for (int i = 0; i < 9; i++)  oct_pix[i]  = (i == o) ? OCT_MARK : OCT_BG;
        for (int i = 0; i < 12; i++) note_pix[i] = (i == n) ? NOTE_MARK : NOTE_BG;
    endtask

    task automatic apply(input int f, input int o, input int n);
        @(negedge clock);
        frequency = 16'(f);
        set_markers(o, n);
        @(posedge clock);
        #1;
    endtask

    task automatic expect_valid(input string tag, input int off, input int pos);
        check({tag, " oct"}, int'(octaveColour), int'(OCT_MARK));
        check({tag, " note"}, int'(noteColour), int'(NOTE_MARK));
        check({tag, " off"}, int'(freqOffset), off);
        check({tag, " pos"}, int'(positive), pos);
    endtask

    task automatic expect_zero(input string tag);
        check({tag, " oct"}, int'(octaveColour), 0);
        check({tag, " note"}, int'(noteColour), 0);
        check({tag, " off"}, int'(freqOffset), 0);
        check({tag, " pos"}, int'(positive), 0);
    endtask

    // freq, valid, octave, note, offset, positive
    int dir [0:14][0:5] = '{
        '{440,   1, 4, 9,  0,   1},
        '{445,   1, 4, 9,  60,  1},
        '{441,   1, 4, 9,  12,  1},
        '{262,   1, 4, 0,  7,   1},
        '{16,    1, 0, 0,  115, 0},
        '{8135,  1, 8, 11, 157, 1},
        '{8136,  0, 0, 0,  0,   0},
        '{15,    0, 0, 0,  0,   0},
        '{0,     0, 0, 0,  0,   0},
        '{65535, 0, 0, 0,  0,   0},
        '{4068,  1, 8, 0,  150, 0},
        '{4309,  1, 8, 0,  157, 1},
        '{4310,  1, 8, 1,  150, 0},
        '{7680,  1, 8, 11, 150, 0},
        '{2033,  1, 6, 11, 155, 1}
    };

    initial begin
        int k, f, fn, d, off, pos;
        string tag;

        reset = 1'b1;
        frequency = 16'd440;
        set_markers(4, 9);
        #2;
        expect_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        expect_valid("first440", 0, 1);

        for (int i = 0; i < 15; i++) begin
            apply(dir[i][0], dir[i][2], dir[i][3]);
            tag = $sformatf("dir%0d", dir[i][0]);
            if (dir[i][1] != 0) expect_valid(tag, dir[i][4], dir[i][5]);
            else expect_zero(tag);
        end

        for (int o = 0; o < 9; o++) begin
            for (int n = 0; n < 12; n++) begin
                k   = 8 - o;
                f   = (nom8[n] + ((1 << k) >> 1)) >> k;
                fn  = f << k;
                d   = fn - nom8[n];
                pos = (d >= 0) ? 1 : 0;
                off = ((d < 0 ? -d : d) * 5354) / nom8[n];
                if (off > 159) off = 159;
                apply(f, o, n);
                tag = $sformatf("sweep o%0d n%0d", o, n);
                expect_valid(tag, off, pos);
                if (o >= 7) check({tag, " small"}, int'(freqOffset <= 12'd2), 1);
            end
        end

        apply(440, 4, 9);
        expect_valid("pre-reset", 0, 1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        expect_zero("async reset");
        @(negedge clock);
        reset = 1'b0;
        #1;
        expect_zero("held after release");
        @(posedge clock);
        #1;
        expect_valid("post-reset", 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
